// File: rtl/m6800_pkg.sv
// Shared definitions for the 6800-style bus emulator: cycle FSM states,
// default timing parameters and the CPU-space function code.
package m6800_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VMA_ACT,
        ST_ACK,
        ST_TERM,
        ST_AVEC_ACT
    } state_t;

    localparam int DEF_DIV       = 10;
    localparam int DEF_E_RISE    = 4;
    localparam int DEF_E_FALL    = 8;
    localparam int DEF_VMA_PHASE = 2;
    localparam int DEF_ACK_PHASE = 8;
    localparam bit DEF_PORT16    = 1'b1;

    localparam logic [2:0] CPU_SPACE = 3'b111;

endpackage

// File: rtl/m6800_eclk.sv
// E-clock timebase: free-running phase counter Q (0..DIV-1), registered E
// output, and one-hot phase strobes decoded from the current Q value.
module m6800_eclk
    import m6800_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int E_RISE    = DEF_E_RISE,
    parameter int E_FALL    = DEF_E_FALL,
    parameter int VMA_PHASE = DEF_VMA_PHASE,
    parameter int ACK_PHASE = DEF_ACK_PHASE
) (
    input  logic                    CLK7M,
    input  logic                    RESET,
    output logic [$clog2(DIV)-1:0]  Q,
    output logic                    E,
    output logic                    vma_stb,
    output logic                    ack_stb,
    output logic                    end_stb
);

    localparam int QW = $clog2(DIV);

    localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);
    localparam logic [QW-1:0] Q_RISE = QW'(E_RISE);
    localparam logic [QW-1:0] Q_FALL = QW'(E_FALL);
    localparam logic [QW-1:0] Q_VMA  = QW'(VMA_PHASE);
    localparam logic [QW-1:0] Q_ACK  = QW'(ACK_PHASE);

    // Phase counter, wrapping at DIV-1
    always_ff @(posedge CLK7M) begin
        if (RESET)
            Q <= '0;
        else if (Q == Q_LAST)
            Q <= '0;
        else
            Q <= Q + 1'b1;
    end

    // E set on the E_RISE edge, cleared on the E_FALL edge, held otherwise
    always_ff @(posedge CLK7M) begin
        if (RESET)
            E <= 1'b0;
        else if (Q == Q_RISE)
            E <= 1'b1;
        else if (Q == Q_FALL)
            E <= 1'b0;
    end

    // Phase strobes: true while Q holds the phase value, acted on at the next edge
    always_comb begin
        vma_stb = (Q == Q_VMA);
        ack_stb = (Q == Q_ACK);
        end_stb = (Q == Q_LAST);
    end

endmodule

// File: rtl/m6800_bus.sv
// 6800-style synchronous bus emulator: qualifies VPA cycles into VMA and
// returns one DSACK termination per AS20 strobe, aligned to E.
// Optional feature macro: M6800_AVEC_EN (autovector for CPU-space VPA cycles).
module m6800_bus
    import m6800_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int E_RISE    = DEF_E_RISE,
    parameter int E_FALL    = DEF_E_FALL,
    parameter int VMA_PHASE = DEF_VMA_PHASE,
    parameter int ACK_PHASE = DEF_ACK_PHASE,
    parameter bit PORT16    = DEF_PORT16
) (
    input  logic                    CLK7M,
    input  logic                    RESET,
    input  logic                    AS20,
    input  logic [2:0]              FC,
    input  logic                    VPA,
    output logic                    E,
    output logic                    VMA,
    output logic [1:0]              DSACK,
    output logic                    AVEC,
    output logic [$clog2(DIV)-1:0]  Q
);

    localparam logic [1:0] DSACK_ON = PORT16 ? 2'b01 : 2'b10;

    state_t     state, state_nxt;
    logic       vma_nxt, avec_nxt;
    logic [1:0] dsack_nxt;
    logic       vma_stb, ack_stb, end_stb;
    logic       cycle_req, cpu_space;

    m6800_eclk #(
        .DIV       (DIV),
        .E_RISE    (E_RISE),
        .E_FALL    (E_FALL),
        .VMA_PHASE (VMA_PHASE),
        .ACK_PHASE (ACK_PHASE)
    ) u_eclk (
        .CLK7M   (CLK7M),
        .RESET   (RESET),
        .Q       (Q),
        .E       (E),
        .vma_stb (vma_stb),
        .ack_stb (ack_stb),
        .end_stb (end_stb)
    );

    // Request qualifiers sampled on every edge
    always_comb begin
        cycle_req = !AS20 && !VPA;
        cpu_space = (FC == CPU_SPACE);
    end

    // State and registered bus outputs
    always_ff @(posedge CLK7M) begin
        if (RESET) begin
            state <= ST_IDLE;
            VMA   <= 1'b1;
            DSACK <= 2'b11;
            AVEC  <= 1'b1;
        end else begin
            state <= state_nxt;
            VMA   <= vma_nxt;
            DSACK <= dsack_nxt;
            AVEC  <= avec_nxt;
        end
    end

    // Cycle sequencing; an abort is checked before any phase strobe
    always_comb begin
        state_nxt = state;
        vma_nxt   = VMA;
        dsack_nxt = DSACK;
        avec_nxt  = AVEC;
        case (state)
            ST_IDLE: begin
                if (vma_stb && cycle_req) begin
                    if (!cpu_space) begin
                        state_nxt = ST_VMA_ACT;
                        vma_nxt   = 1'b0;
                    end
`ifdef M6800_AVEC_EN
                    else begin
                        state_nxt = ST_AVEC_ACT;
                        avec_nxt  = 1'b0;
                    end
`endif
                end
            end
            ST_VMA_ACT: begin
                if (!cycle_req) begin
                    state_nxt = ST_IDLE;
                    vma_nxt   = 1'b1;
                    dsack_nxt = 2'b11;
                end else if (ack_stb) begin
                    state_nxt = ST_ACK;
                    dsack_nxt = DSACK_ON;
                end
            end
            ST_ACK: begin
                if (!cycle_req || end_stb) begin
                    state_nxt = cycle_req ? ST_TERM : ST_IDLE;
                    vma_nxt   = 1'b1;
                    dsack_nxt = 2'b11;
                end
            end
            ST_TERM: begin
                if (AS20)
                    state_nxt = ST_IDLE;
            end
`ifdef M6800_AVEC_EN
            ST_AVEC_ACT: begin
                if (AS20) begin
                    state_nxt = ST_IDLE;
                    avec_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                vma_nxt   = 1'b1;
                dsack_nxt = 2'b11;
                avec_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_m6800_bus.sv
// Scoreboard bench for m6800_bus: default timing with 16-bit and 8-bit
// termination, plus a DIV=6 instance with its own reset.
module tb_m6800_bus;

    typedef struct {
        bit   is_c;
        int   q;
        logic e;
        logic vma;
        logic ack;
        logic avec;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   bq  = 0;
    int   bqc = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       as20 = 1'b1;
    logic       vpa = 1'b1;
    logic [2:0] fc = 3'b101;
    logic       rst_c = 1'b1;
    logic       as_c = 1'b1;
    logic       vpa_c = 1'b1;
    logic [2:0] fc_c = 3'b101;

    logic       e_a, vma_a, avec_a;
    logic [1:0] dsack_a;
    logic [3:0] q_a;
    logic       e_b, vma_b, avec_b;
    logic [1:0] dsack_b;
    logic [3:0] q_b;
    logic       e_c, vma_c, avec_c;
    logic [1:0] dsack_c;
    logic [2:0] q_c;

    m6800_bus #(.PORT16(1'b1)) dut_a (
        .CLK7M(clk), .RESET(reset), .AS20(as20), .FC(fc), .VPA(vpa),
        .E(e_a), .VMA(vma_a), .DSACK(dsack_a), .AVEC(avec_a), .Q(q_a)
    );

    m6800_bus #(.PORT16(1'b0)) dut_b (
        .CLK7M(clk), .RESET(reset), .AS20(as20), .FC(fc), .VPA(vpa),
        .E(e_b), .VMA(vma_b), .DSACK(dsack_b), .AVEC(avec_b), .Q(q_b)
    );

    m6800_bus #(.DIV(6), .E_RISE(2), .E_FALL(4), .VMA_PHASE(1), .ACK_PHASE(4)) dut_c (
        .CLK7M(clk), .RESET(rst_c), .AS20(as_c), .FC(fc_c), .VPA(vpa_c),
        .E(e_c), .VMA(vma_c), .DSACK(dsack_c), .AVEC(avec_c), .Q(q_c)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Default-timing instances: one step = inputs for the next edge plus expectation after it
    task automatic step_ab(input logic rst, input logic as, input logic vp, input logic [2:0] f,
                           input logic vma_e, input logic ack_e, input logic avec_e);
        exp_t x;
        @(negedge clk);
        reset = rst;
        as20  = as;
        vpa   = vp;
        fc    = f;
        bq    = rst ? 0 : (bq + 1) % 10;
        x.is_c = 1'b0;
        x.q    = bq;
        x.e    = (bq >= 5 && bq <= 8);
        x.vma  = vma_e;
        x.ack  = ack_e;
        x.avec = avec_e;
        sbq.push_back(x);
    endtask

    task automatic step_c(input logic rst, input logic as, input logic vma_e, input logic ack_e);
        exp_t x;
        @(negedge clk);
        rst_c = rst;
        as_c  = as;
        vpa_c = as;
        bqc   = rst ? 0 : (bqc + 1) % 6;
        x.is_c = 1'b1;
        x.q    = bqc;
        x.e    = (bqc >= 3 && bqc <= 4);
        x.vma  = vma_e;
        x.ack  = ack_e;
        x.avec = 1'b1;
        sbq.push_back(x);
    endtask

    // Monitor: after each edge, compare outputs against the oldest expectation
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            if (!x.is_c) begin
                chk("a_q", int'(q_a), x.q);
                chk("a_e", int'(e_a), int'(x.e));
                chk("a_vma", int'(vma_a), int'(x.vma));
                chk("a_dsack", int'(dsack_a), x.ack ? 1 : 3);
                chk("a_avec", int'(avec_a), int'(x.avec));
                chk("b_vma", int'(vma_b), int'(x.vma));
                chk("b_dsack", int'(dsack_b), x.ack ? 2 : 3);
            end else begin
                chk("c_q", int'(q_c), x.q);
                chk("c_e", int'(e_c), int'(x.e));
                chk("c_vma", int'(vma_c), int'(x.vma));
                chk("c_dsack", int'(dsack_c), x.ack ? 1 : 3);
                chk("c_avec", int'(avec_c), int'(x.avec));
            end
        end
    end

    initial begin
        int q;
        // reset state
        step_ab(1, 1, 1, 3'b101, 1, 0, 1);
        step_ab(1, 1, 1, 3'b101, 1, 0, 1);
        // free run, two periods, ends with DUT Q=0
        repeat (20) step_ab(0, 1, 1, 3'b101, 1, 0, 1);

        // VPA cycle applied at Q=0: VMA low Q=3..9, DSACK low Q=9
        for (int i = 1; i <= 10; i++) begin
            q = i % 10;
            step_ab(0, 0, 0, 3'b101, !(q >= 3 && q <= 9), q == 9, 1);
        end
        // strobe held two more periods: no second termination
        repeat (20) step_ab(0, 0, 0, 3'b101, 1, 0, 1);
        repeat (10) step_ab(0, 1, 1, 3'b101, 1, 0, 1);

        // abort: AS20 high while Q=6 -> VMA high from Q=7, no DSACK
        for (int i = 1; i <= 10; i++) begin
            q = i % 10;
            if (i <= 6)
                step_ab(0, 0, 0, 3'b101, !(q >= 3), 0, 1);
            else
                step_ab(0, 1, 1, 3'b101, 1, 0, 1);
        end
        repeat (10) step_ab(0, 1, 1, 3'b101, 1, 0, 1);

        // CPU-space VPA cycle, AS20 released while Q=15%10=5
        for (int i = 1; i <= 20; i++) begin
`ifdef M6800_AVEC_EN
            step_ab(0, i > 15, i > 15, 3'b111, 1, 0, !(i >= 3 && i <= 15));
`else
            step_ab(0, i > 15, i > 15, 3'b111, 1, 0, 1);
`endif
        end

        // request arriving at Q=5 waits for the next period's VMA phase
        repeat (5) step_ab(0, 1, 1, 3'b101, 1, 0, 1);
        for (int i = 6; i <= 19; i++)
            step_ab(0, 0, 0, 3'b101, !(i >= 13), i == 19, 1);
        step_ab(0, 1, 1, 3'b101, 1, 0, 1);

        // DIV=6 instance
        step_c(1, 1, 1, 0);
        repeat (6) step_c(0, 1, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            q = i % 6;
            step_c(0, 0, !(q >= 2 && q <= 5), q == 5);
        end
        repeat (6) step_c(0, 1, 1, 0);
        for (int i = 1; i <= 3; i++)
            step_c(0, 0, !(i >= 2), 0);
        // reset pulsed while Q=3 mid-cycle
        step_c(1, 0, 1, 0);
        repeat (6) step_c(0, 1, 1, 0);

        @(negedge clk);
        @(negedge clk);
        chk("drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
